// File: rtl/bin2bcd_seq.sv
// Sequential 27-bit binary to 8-digit packed BCD converter (double dabble, fixed 27-cycle latency).
// Define OVF_SATURATE_EN to show 9999_9999 instead of EEEE_EEEE on out-of-range input.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [26:0] bin,
    output logic [32:1] bcd,
    output logic        busy,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [26:0] MAX_IN_RANGE = 27'd99_999_999;
    localparam logic [4:0]  LAST_CNT     = 5'd26;
`ifdef OVF_SATURATE_EN
    localparam logic [31:0] OVF_PATTERN  = 32'h9999_9999;
`else
    localparam logic [31:0] OVF_PATTERN  = 32'hEEEE_EEEE;
`endif

    state_t      state_q, state_d;
    logic [26:0] shreg_q, shreg_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] adj;
    logic [4:0]  cnt_q, cnt_d;
    logic        range_q, range_d;
    logic [32:1] bcd_q, bcd_d;
    logic        ovf_q, ovf_d;

    function automatic logic [31:0] add3(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT) || (state_q == DONE);
        done = (state_q == DONE);
    end

    assign bcd = bcd_q;
    assign ovf = ovf_q;

    always_comb begin
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        range_d   = range_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        adj       = add3(scratch_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = 32'h0;
                    cnt_d     = 5'd0;
                    range_d   = (bin > MAX_IN_RANGE);
                end
            end
            SHIFT: begin
                scratch_d = {adj[30:0], shreg_q[26]};
                shreg_d   = {shreg_q[25:0], 1'b0};
                cnt_d     = cnt_q + 5'd1;
                // Outputs only move on the final shift, so the display never sees partial digits.
                if (cnt_q == LAST_CNT) begin
                    bcd_d = range_q ? OVF_PATTERN : scratch_d;
                    ovf_d = range_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= 27'h0;
            scratch_q <= 32'h0;
            cnt_q     <= 5'd0;
            range_q   <= 1'b0;
            bcd_q     <= 32'h0;
            ovf_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            range_q   <= range_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, held start, reset abort, random values.
// Honours OVF_SATURATE_EN the same way as the design.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [26:0] bin = 27'h0;
    logic [32:1] bcd;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] prev_bcd = 32'h0;
    logic        prev_ovf = 1'b0;

`ifdef OVF_SATURATE_EN
    localparam logic [31:0] OVF_EXP = 32'h9999_9999;
`else
    localparam logic [31:0] OVF_EXP = 32'hEEEE_EEEE;
`endif

    bin2bcd_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .bin  (bin),
        .bcd  (bcd),
        .busy (busy),
        .done (done),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Decimal digits by repeated division; out-of-range maps to the fixed pattern.
    function automatic void model(input logic [26:0] v, output logic [31:0] b, output logic o);
        int unsigned x;
        x = 32'(v);
        b = 32'h0;
        o = (x > 32'd99_999_999);
        if (o) b = OVF_EXP;
        else begin
            for (int d = 0; d < 8; d++) begin
                b[4*d +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
    endfunction

    // One conversion from IDLE; checks every cycle from accept edge N through N+29.
    task automatic do_conv(input logic [26:0] v, input bit change_bin);
        logic [31:0] exp_bcd;
        logic        exp_ovf;
        logic [34:0] got, want;
        model(v, exp_bcd, exp_ovf);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            if (change_bin && k == 3) bin = 27'd5;
            else if (k >= 2) start = k[0];
            if (k <= 27)       want = {1'b1, 1'b0, prev_ovf, prev_bcd};
            else if (k == 28)  want = {1'b1, 1'b1, exp_ovf, exp_bcd};
            else               want = {1'b0, 1'b0, exp_ovf, exp_bcd};
            got = {busy, done, ovf, bcd};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL conv bin=%0d cycle=N+%0d {busy,done,ovf,bcd}: got %h want %h", v, k, got, want);
            end
            if (k < 29) @(negedge clk);
        end
        start    = 1'b0;
        prev_bcd = exp_bcd;
        prev_ovf = exp_ovf;
    endtask

    task automatic test_reset();
        start = 1'b0;
        rst   = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, ovf, bcd} !== 35'h0) begin
            n_err++;
            $display("FAIL reset outputs: got %h want 0", {busy, done, ovf, bcd});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        prev_bcd = 32'h0;
        prev_ovf = 1'b0;
    endtask

    task automatic test_directed();
        do_conv(27'd0, 1'b0);
        do_conv(27'd12_345_678, 1'b1);
        do_conv(27'd99_999_999, 1'b0);
        do_conv(27'd100_000_000, 1'b0);
        do_conv(27'd9, 1'b0);
        do_conv(27'h7FF_FFFF, 1'b0);
        do_conv(27'd10, 1'b0);
    endtask

    task automatic test_back_to_back();
        int pulses;
        int last;
        @(negedge clk);
        start  = 1'b1;
        bin    = 27'd42;
        pulses = 0;
        last   = 0;
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (last > 0) begin
                    n_cmp++;
                    if (i - last != 29) begin
                        n_err++;
                        $display("FAIL b2b interval: got %0d want 29", i - last);
                    end
                end
                last = i;
            end
            if (pulses > 0) begin
                n_cmp++;
                if ({ovf, bcd} !== {1'b0, 32'h0000_0042}) begin
                    n_err++;
                    $display("FAIL b2b result cycle %0d: got %h want 000000042", i, {ovf, bcd});
                end
            end
        end
        n_cmp++;
        if (pulses != 4) begin
            n_err++;
            $display("FAIL b2b pulse count: got %0d want 4", pulses);
        end
        start = 1'b0;
        repeat (32) @(negedge clk);
        prev_bcd = 32'h0000_0042;
        prev_ovf = 1'b0;
    endtask

    task automatic test_reset_abort();
        int stray;
        do_conv(27'd7, 1'b0);
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd555;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, ovf, bcd} !== 35'h0) begin
            n_err++;
            $display("FAIL abort outputs: got %h want 0", {busy, done, ovf, bcd});
        end
        @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL abort stray activity: got %0d cycles want 0", stray);
        end
        prev_bcd = 32'h0;
        prev_ovf = 1'b0;
        do_conv(27'd555, 1'b0);
    endtask

    task automatic test_random();
        logic [26:0] v;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) v = 27'($urandom_range(0, 99_999_999));
            else            v = 27'($urandom);
            do_conv(v, (i % 3 == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
